// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and decoder-enable constants for scan_seq
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BLANK = 2'd2
    } scan_state_e;

    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam logic [2:0] EN_OFF    = 3'b000;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter that flags when the dwell count is exhausted
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins over counting; the count saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/scan_seq.sv
// rtl/scan_seq.sv - channel-scan sequencer driving the x74138 select/enable pins (optional SCAN_BLANK_EN)
module scan_seq
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [2:0]         first,
    input  logic [2:0]         last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         En,
    output logic [2:0]         I,
    output logic               busy,
    output logic               done,
    output logic               frame
);

    scan_state_e state_q, state_d;
    logic [2:0]  en_q, en_d;
    logic [2:0]  i_q, i_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        frame_q, frame_d;
    logic        single_q, single_d;
    logic [2:0]  next_ch;
    logic        tmr_load;
    logic        tmr_zero;
`ifdef SCAN_BLANK_EN
    // remembers that the channel loaded in BLANK is a wrap, so frame fires on the following RUN cycle
    logic        wrap_q, wrap_d;
`endif

    dwell_timer #(
        .W(DWELL_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .value(dwell),
        .zero (tmr_zero)
    );

    // channel following the current one; first is re-sampled at the wrap
    always_comb begin
        next_ch = (i_q == last) ? first : (i_q + 3'd1);
    end

    // next-state and registered-output logic; stop overrides everything but rst
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frame_d  = 1'b0;
        single_d = single_q;
        tmr_load = 1'b0;
`ifdef SCAN_BLANK_EN
        wrap_d   = wrap_q;
`endif
        if (stop) begin
            state_d = S_IDLE;
            en_d    = EN_OFF;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_d   = EN_OFF;
                    busy_d = 1'b0;
                    if (start) begin
                        state_d  = S_RUN;
                        i_d      = first;
                        single_d = single;
                        en_d     = EN_ACTIVE;
                        busy_d   = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                S_RUN: begin
                    if (tmr_zero) begin
                        if ((i_q == last) && single_q) begin
                            state_d = S_IDLE;
                            en_d    = EN_OFF;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            i_d = next_ch;
`ifdef SCAN_BLANK_EN
                            state_d = S_BLANK;
                            en_d    = EN_OFF;
                            wrap_d  = (i_q == last);
`else
                            tmr_load = 1'b1;
                            frame_d  = (i_q == last);
`endif
                        end
                    end
                end
`ifdef SCAN_BLANK_EN
                S_BLANK: begin
                    // the slot timer starts here so the channel still gets dwell+1 active cycles
                    state_d  = S_RUN;
                    en_d     = EN_ACTIVE;
                    tmr_load = 1'b1;
                    frame_d  = wrap_q;
                    wrap_d   = 1'b0;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    en_d    = EN_OFF;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            en_q     <= EN_OFF;
            i_q      <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frame_q  <= 1'b0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            i_q      <= i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frame_q  <= frame_d;
            single_q <= single_d;
        end
    end

`ifdef SCAN_BLANK_EN
    // wrap flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
`endif

    assign En    = en_q;
    assign I     = i_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_scan_seq.sv
// tb/tb_scan_seq.sv - table-driven self-checking bench for scan_seq
module tb_scan_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       single;
    logic [2:0] first;
    logic [2:0] last;
    logic [7:0] dwell;
    logic [2:0] En;
    logic [2:0] I;
    logic       busy;
    logic       done;
    logic       frame;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       st;
        logic       sp;
        logic       sg;
        logic [2:0] f;
        logic [2:0] l;
        logic [7:0] d;
        logic [2:0] en;
        logic [2:0] i;
        logic       b;
        logic       dn;
        logic       fr;
    } vec_t;

    vec_t vecs[$];

    scan_seq #(
        .DWELL_W(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .single(single),
        .first (first),
        .last  (last),
        .dwell (dwell),
        .En    (En),
        .I     (I),
        .busy  (busy),
        .done  (done),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic add(input logic st, input logic sp, input logic sg, input logic [2:0] f,
                       input logic [2:0] l, input logic [7:0] d, input logic [2:0] en,
                       input logic [2:0] i, input logic b, input logic dn, input logic fr);
        vec_t v;
        v.st = st; v.sp = sp; v.sg = sg; v.f = f; v.l = l; v.d = d;
        v.en = en; v.i = i; v.b = b; v.dn = dn; v.fr = fr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [2:0] en, input logic [2:0] i,
                             input logic b, input logic dn, input logic fr);
        chk({tag, ".En"},    idx, {5'd0, En},    {5'd0, en});
        chk({tag, ".I"},     idx, {5'd0, I},     {5'd0, i});
        chk({tag, ".busy"},  idx, {7'd0, busy},  {7'd0, b});
        chk({tag, ".done"},  idx, {7'd0, done},  {7'd0, dn});
        chk({tag, ".frame"}, idx, {7'd0, frame}, {7'd0, fr});
    endtask

    task automatic drive(input logic st, input logic sp, input logic sg, input logic [2:0] f,
                         input logic [2:0] l, input logic [7:0] d);
        start = st; stop = sp; single = sg; first = f; last = l; dwell = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0;
        first = 3'd0; last = 3'd0; dwell = 8'd0;

`ifndef SCAN_BLANK_EN
        // single pass 0..7, dwell 0
        add(1,0,1, 3'd0,3'd7,8'd0, 3'b100,3'd0,1,0,0);
        for (int k = 1; k < 8; k++) add(0,0,1, 3'd0,3'd7,8'd0, 3'b100,3'(k),1,0,0);
        add(0,0,1, 3'd0,3'd7,8'd0, 3'b000,3'd7,0,1,0);
        add(0,0,1, 3'd0,3'd7,8'd0, 3'b000,3'd7,0,0,0);
        // single pass 2..3, dwell 2
        add(1,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd2,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd2,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd2,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd3,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd3,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b100,3'd3,1,0,0);
        add(0,0,1, 3'd2,3'd3,8'd2, 3'b000,3'd3,0,1,0);
        // continuous 6..1 through the 7->0 wrap; start+single while busy is ignored
        add(1,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd6,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd7,1,0,0);
        add(1,0,1, 3'd6,3'd1,8'd0, 3'b100,3'd0,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd1,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd6,1,0,1);
        add(1,0,1, 3'd6,3'd1,8'd0, 3'b100,3'd7,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd0,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd1,1,0,0);
        add(0,0,0, 3'd6,3'd1,8'd0, 3'b100,3'd6,1,0,1);
        add(0,1,0, 3'd6,3'd1,8'd0, 3'b000,3'd6,0,0,0);
        // continuous 2..5, stop while I=3, then start+stop together
        add(1,0,0, 3'd2,3'd5,8'd0, 3'b100,3'd2,1,0,0);
        add(0,0,0, 3'd2,3'd5,8'd0, 3'b100,3'd3,1,0,0);
        add(0,1,0, 3'd2,3'd5,8'd0, 3'b000,3'd3,0,0,0);
        add(1,1,0, 3'd2,3'd5,8'd0, 3'b000,3'd3,0,0,0);
        add(0,0,0, 3'd2,3'd5,8'd0, 3'b000,3'd3,0,0,0);
        // first==last: single pass of one channel, then continuous pulses frame each cycle
        add(1,0,1, 3'd4,3'd4,8'd0, 3'b100,3'd4,1,0,0);
        add(0,0,1, 3'd4,3'd4,8'd0, 3'b000,3'd4,0,1,0);
        add(1,0,0, 3'd5,3'd5,8'd0, 3'b100,3'd5,1,0,0);
        add(0,0,0, 3'd5,3'd5,8'd0, 3'b100,3'd5,1,0,1);
        add(0,0,0, 3'd5,3'd5,8'd0, 3'b100,3'd5,1,0,1);
        add(0,1,0, 3'd5,3'd5,8'd0, 3'b000,3'd5,0,0,0);
`else
        // single pass 0..2, dwell 1, with a blank cycle between slots
        add(1,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd0,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd0,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b000,3'd1,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd1,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd1,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b000,3'd2,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd2,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b100,3'd2,1,0,0);
        add(0,0,1, 3'd0,3'd2,8'd1, 3'b000,3'd2,0,1,0);
        // continuous 6..7: frame on first RUN cycle after the wrap blank, then stop in BLANK
        add(1,0,0, 3'd6,3'd7,8'd0, 3'b100,3'd6,1,0,0);
        add(0,0,0, 3'd6,3'd7,8'd0, 3'b000,3'd7,1,0,0);
        add(0,0,0, 3'd6,3'd7,8'd0, 3'b100,3'd7,1,0,0);
        add(0,0,0, 3'd6,3'd7,8'd0, 3'b000,3'd6,1,0,0);
        add(0,0,0, 3'd6,3'd7,8'd0, 3'b100,3'd6,1,0,1);
        add(0,0,0, 3'd6,3'd7,8'd0, 3'b000,3'd7,1,0,0);
        add(0,1,0, 3'd6,3'd7,8'd0, 3'b000,3'd7,0,0,0);
`endif

        // reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0,0,0, 3'd0,3'd0,8'd0);
        check_all("reset", 0, 3'b000, 3'd0, 0, 0, 0);

        foreach (vecs[n]) begin
            drive(vecs[n].st, vecs[n].sp, vecs[n].sg, vecs[n].f, vecs[n].l, vecs[n].d);
            check_all("vec", n, vecs[n].en, vecs[n].i, vecs[n].b, vecs[n].dn, vecs[n].fr);
        end

        // reset in the middle of a continuous scan clears everything on that edge
        drive(1,0,0, 3'd3,3'd6,8'd4);
        check_all("pre_rst", 0, 3'b100, 3'd3, 1, 0, 0);
        rst = 1'b1;
        drive(0,0,0, 3'd3,3'd6,8'd4);
        check_all("mid_rst", 0, 3'b000, 3'd0, 0, 0, 0);
        rst = 1'b0;
        drive(0,0,0, 3'd3,3'd6,8'd4);
        check_all("post_rst", 0, 3'b000, 3'd0, 0, 0, 0);

        // dwell 4 single channel: active for exactly five cycles
        drive(1,0,1, 3'd1,3'd1,8'd4);
        for (int c = 0; c < 5; c++) begin
            check_all("dwell4", c, 3'b100, 3'd1, 1, 0, 0);
            if (c < 4) drive(0,0,1, 3'd1,3'd1,8'd4);
        end
        drive(0,0,1, 3'd1,3'd1,8'd4);
        check_all("dwell4_end", 0, 3'b000, 3'd1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
